// File: rtl/boot_pkg.sv
// Shared types and default constants for the UART boot sequencer.
package boot_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ACK  = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } boot_state_e;

  localparam logic [31:0] END_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [7:0]  ACK_BYTE_DEF = 8'hAA;
  localparam logic [7:0]  NAK_BYTE_DEF = 8'h15;
  localparam int          TIMEOUT_DEF  = 4096;

  // Big-endian assembly: the three older bytes sit above the newest one.
  function automatic logic [31:0] pack_be(input logic [23:0] older, input logic [7:0] newest);
    return {older, newest};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles received bytes into big-endian 32-bit words and drops a partial
// word that has sat idle for TIMEOUT clocks.
module byte_packer
  import boot_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [23:0]   shift_q, shift_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    if (!en) begin
      byte_cnt_d = '0;
      idle_cnt_d = '0;
    end else if (rx_valid) begin
      shift_d    = {shift_q[15:0], rx_data};
      byte_cnt_d = byte_cnt_q + 2'd1;
      idle_cnt_d = '0;
    end else if (byte_cnt_q != 2'd0) begin
      // Stale partial word: forget its bytes, the shift register gets overwritten anyway.
      if (idle_cnt_q == IDLE_LAST) begin
        byte_cnt_d = '0;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // The word completes in the same cycle as its 4th byte; the caller registers it.
  assign word       = pack_be(shift_q, rx_data);
  assign word_valid = en && rx_valid && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot sequencer: loads instruction memory from UART bytes, answers with
// ACK/NAK on TX, then releases the CPU and forwards bytes to it.
module uart_boot_ctrl
  import boot_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] END_WORD = END_WORD_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF,
  parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE = NAK_BYTE_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              cpu_rst_n,
  output logic              cpu_in_valid,
  output logic [7:0]        cpu_in_data,
  output logic              load_done,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              cpu_in_valid_q, cpu_in_valid_d;
  logic [7:0]        cpu_in_data_q, cpu_in_data_d;
  logic              load_done_q, load_done_d;
  logic              err_overflow_q, err_overflow_d;

  logic [31:0] word;
  logic        word_valid;

  byte_packer #(
    .TIMEOUT (TIMEOUT)
  ) u_packer (
    .clk        (CLK),
    .rst_n      (RSTN),
    .en         (state_q == LOAD),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    tx_valid_d     = tx_valid_q;
    tx_data_d      = tx_data_q;
    cpu_rst_n_d    = cpu_rst_n_q;
    cpu_in_valid_d = 1'b0;
    cpu_in_data_d  = cpu_in_data_q;
    load_done_d    = load_done_q;
    err_overflow_d = err_overflow_q;

    case (state_q)
      LOAD: begin
        if (word_valid) begin
          if (word == END_WORD) begin
            state_d    = ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q;
            imem_wdata_d = word;
            word_cnt_d   = word_cnt_q + 1'b1;
            // Filling the last slot without a terminator means the image did not fit.
            if (word_cnt_q == ADDR_LAST) begin
              err_overflow_d = 1'b1;
              state_d        = ACK;
              tx_valid_d     = 1'b1;
              tx_data_d      = NAK_BYTE;
            end
          end
        end
      end
      ACK: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (err_overflow_q) begin
            state_d = HALT;
          end else begin
            state_d     = RUN;
            cpu_rst_n_d = 1'b1;
            load_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rx_valid) begin
          cpu_in_valid_d = 1'b1;
          cpu_in_data_d  = rx_data;
        end
      end
      HALT: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q        <= LOAD;
      word_cnt_q     <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
      cpu_rst_n_q    <= 1'b0;
      cpu_in_valid_q <= 1'b0;
      cpu_in_data_q  <= '0;
      load_done_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      cpu_rst_n_q    <= cpu_rst_n_d;
      cpu_in_valid_q <= cpu_in_valid_d;
      cpu_in_data_q  <= cpu_in_data_d;
      load_done_q    <= load_done_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign cpu_in_valid = cpu_in_valid_q;
  assign cpu_in_data  = cpu_in_data_q;
  assign load_done    = load_done_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Scoreboard bench for uart_boot_ctrl: a default-size instance and a tiny
// ADDR_W=2 instance for the overflow path.
module tb_uart_boot_ctrl;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic        a_rx_valid = 1'b0, b_rx_valid = 1'b0;
  logic [7:0]  a_rx_data = 8'h00, b_rx_data = 8'h00;
  logic        a_tx_ready = 1'b0, b_tx_ready = 1'b0;

  logic        a_imem_we, a_tx_valid, a_cpu_rst_n, a_cpu_in_valid, a_load_done, a_err_overflow;
  logic [13:0] a_imem_addr;
  logic [31:0] a_imem_wdata;
  logic [7:0]  a_tx_data, a_cpu_in_data;

  logic        b_imem_we, b_tx_valid, b_cpu_rst_n, b_cpu_in_valid, b_load_done, b_err_overflow;
  logic [1:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic [7:0]  b_tx_data, b_cpu_in_data;

  uart_boot_ctrl dut_a (
    .CLK(CLK), .RSTN(RSTN), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
    .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
    .cpu_rst_n(a_cpu_rst_n), .cpu_in_valid(a_cpu_in_valid), .cpu_in_data(a_cpu_in_data),
    .load_done(a_load_done), .err_overflow(a_err_overflow)
  );

  uart_boot_ctrl #(.ADDR_W(2)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
    .cpu_rst_n(b_cpu_rst_n), .cpu_in_valid(b_cpu_in_valid), .cpu_in_data(b_cpu_in_data),
    .load_done(b_load_done), .err_overflow(b_err_overflow)
  );

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } byte_t;

  wr_t   a_wr_q[$];
  wr_t   b_wr_q[$];
  byte_t a_cpu_q[$];
  wr_t   a_e, b_e;
  byte_t c_e;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitors: pop expected transactions as the DUTs produce them.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (a_imem_we) begin
        $display("A WR   addr=%0h data=%08h cyc=%0d", a_imem_addr, a_imem_wdata, cyc);
        if (a_wr_q.size() == 0) begin
          check("a_wr_unexpected", a_imem_we, 1'b0);
        end else begin
          a_e = a_wr_q.pop_front();
          check("a_wr_addr", a_imem_addr, a_e.addr);
          check("a_wr_data", a_imem_wdata, a_e.data);
          check("a_wr_cyc", cyc, a_e.cyc);
        end
      end
      if (a_cpu_in_valid) begin
        $display("A CPU  data=%02h cyc=%0d", a_cpu_in_data, cyc);
        if (a_cpu_q.size() == 0) begin
          check("a_cpu_unexpected", a_cpu_in_valid, 1'b0);
        end else begin
          c_e = a_cpu_q.pop_front();
          check("a_cpu_data", a_cpu_in_data, c_e.data);
          check("a_cpu_cyc", cyc, c_e.cyc);
        end
      end
      if (b_imem_we) begin
        $display("B WR   addr=%0h data=%08h cyc=%0d", b_imem_addr, b_imem_wdata, cyc);
        if (b_wr_q.size() == 0) begin
          check("b_wr_unexpected", b_imem_we, 1'b0);
        end else begin
          b_e = b_wr_q.pop_front();
          check("b_wr_addr", {12'd0, b_imem_addr}, b_e.addr);
          check("b_wr_data", b_imem_wdata, b_e.data);
          check("b_wr_cyc", cyc, b_e.cyc);
        end
      end
      if (b_cpu_in_valid) check("b_cpu_unexpected", b_cpu_in_valid, 1'b0);
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] b);
    @(posedge CLK); #1;
    if (sel) begin b_rx_valid = 1'b1; b_rx_data = b; end
    else     begin a_rx_valid = 1'b1; a_rx_data = b; end
    @(posedge CLK); #1;
    a_rx_valid = 1'b0;
    b_rx_valid = 1'b0;
  endtask

  // After the 4th byte returns, cyc is the cycle in which the write must appear.
  task automatic send_word(input bit sel, input logic [31:0] w, input bit push, input logic [13:0] addr);
    wr_t e;
    for (int i = 3; i >= 0; i--) send_byte(sel, w[8*i +: 8]);
    if (push) begin
      e.addr = addr; e.data = w; e.cyc = cyc;
      if (sel) b_wr_q.push_back(e);
      else     a_wr_q.push_back(e);
    end
  endtask

  task automatic send_cpu_byte(input logic [7:0] b);
    byte_t e;
    send_byte(1'b0, b);
    e.data = b; e.cyc = cyc;
    a_cpu_q.push_back(e);
  endtask

  task automatic wait_tx(input bit sel);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (sel ? b_tx_valid : a_tx_valid) break;
    end
    check("tx_valid_wait", sel ? b_tx_valid : a_tx_valid, 1'b1);
    $display("%s TX   data=%02h cyc=%0d", sel ? "B" : "A", sel ? b_tx_data : a_tx_data, cyc);
  endtask

  task automatic handshake(input bit sel);
    @(posedge CLK); #1;
    if (sel) b_tx_ready = 1'b1; else a_tx_ready = 1'b1;
    @(posedge CLK); #1;
    a_tx_ready = 1'b0;
    b_tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RSTN = 1'b0;
    a_rx_valid = 1'b0; b_rx_valid = 1'b0;
    a_tx_ready = 1'b0; b_tx_ready = 1'b0;
    @(negedge CLK);
    check("rst_a_imem", {a_imem_we, a_imem_addr, a_imem_wdata}, 64'd0);
    check("rst_a_tx", {a_tx_valid, a_tx_data}, 64'd0);
    check("rst_a_cpu", {a_cpu_rst_n, a_cpu_in_valid, a_cpu_in_data}, 64'd0);
    check("rst_a_flags", {a_load_done, a_err_overflow}, 64'd0);
    check("rst_b_all", {b_imem_we, b_imem_addr, b_imem_wdata, b_tx_valid, b_tx_data,
                        b_cpu_rst_n, b_cpu_in_valid, b_cpu_in_data, b_load_done, b_err_overflow}, 64'd0);
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
  endtask

  initial begin
    do_reset();

    // Overflow on the 4-word instance: four writes, NAK, then HALT.
    send_word(1'b1, 32'h0000_1111, 1'b1, 14'd0);
    send_word(1'b1, 32'h0000_2222, 1'b1, 14'd1);
    send_word(1'b1, 32'h0000_3333, 1'b1, 14'd2);
    send_word(1'b1, 32'h0000_4444, 1'b1, 14'd3);
    wait_tx(1'b1);
    check("ovf_tx_data", b_tx_data, 8'h15);
    check("ovf_flag", b_err_overflow, 1'b1);
    check("ovf_cpu_rst_ack", b_cpu_rst_n, 1'b0);
    handshake(1'b1);
    @(negedge CLK);
    check("halt_tx_valid", b_tx_valid, 1'b0);
    check("halt_cpu_rst", b_cpu_rst_n, 1'b0);
    check("halt_load_done", b_load_done, 1'b0);
    check("halt_ovf", b_err_overflow, 1'b1);
    send_word(1'b1, 32'h0102_0304, 1'b0, 14'd0);
    repeat (3) @(negedge CLK);

    // One word then END_WORD, then CPU forwarding in RUN.
    send_word(1'b0, 32'h1234_5678, 1'b1, 14'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 14'd0);
    wait_tx(1'b0);
    check("t1_tx_data", a_tx_data, 8'hAA);
    check("t1_cpu_rst_ack", a_cpu_rst_n, 1'b0);
    handshake(1'b0);
    @(negedge CLK);
    check("t1_cpu_rst_run", a_cpu_rst_n, 1'b1);
    check("t1_load_done", a_load_done, 1'b1);
    check("t1_tx_idle", a_tx_valid, 1'b0);
    check("t1_no_ovf", a_err_overflow, 1'b0);
    send_cpu_byte(8'h55);
    send_cpu_byte(8'h00);
    send_cpu_byte(8'hFF);
    send_cpu_byte(8'hFF);
    repeat (3) @(negedge CLK);
    check("run_load_done", a_load_done, 1'b1);

    // Three words, END_WORD, ACK held 50 cycles; bytes during ACK are dropped.
    do_reset();
    send_word(1'b0, 32'hA0A1_A2A3, 1'b1, 14'd0);
    send_word(1'b0, 32'hB0B1_B2B3, 1'b1, 14'd1);
    send_word(1'b0, 32'hC0C1_C2C3, 1'b1, 14'd2);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 14'd0);
    wait_tx(1'b0);
    send_word(1'b0, 32'hDEAD_BEEF, 1'b0, 14'd0);
    repeat (50) begin
      @(negedge CLK);
      check("hold_valid", a_tx_valid, 1'b1);
      check("hold_data", a_tx_data, 8'hAA);
      check("hold_cpu_rst", a_cpu_rst_n, 1'b0);
    end
    @(posedge CLK); #1 a_tx_ready = 1'b1;
    @(negedge CLK);
    check("hs_cycle_cpu_rst", a_cpu_rst_n, 1'b0);
    @(posedge CLK); #1 a_tx_ready = 1'b0;
    @(negedge CLK);
    check("hs_next_cpu_rst", a_cpu_rst_n, 1'b1);
    check("hs_next_done", a_load_done, 1'b1);
    check("hs_next_tx", a_tx_valid, 1'b0);

    // Idle timeout drops a partial word; a shorter gap keeps it.
    do_reset();
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    repeat (4100) @(posedge CLK);
    send_word(1'b0, 32'hABCD_EF01, 1'b1, 14'd0);
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    repeat (3000) @(posedge CLK);
    send_byte(1'b0, 8'h56);
    send_byte(1'b0, 8'h78);
    a_e.addr = 14'd1; a_e.data = 32'h1234_5678; a_e.cyc = cyc;
    a_wr_q.push_back(a_e);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 14'd0);
    wait_tx(1'b0);
    check("to_tx_data", a_tx_data, 8'hAA);
    handshake(1'b0);
    @(negedge CLK);
    check("to_load_done", a_load_done, 1'b1);

    // Reset mid-word: registered outputs clear and the address restarts at 0.
    do_reset();
    send_word(1'b0, 32'h1122_3344, 1'b1, 14'd0);
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    do_reset();
    send_word(1'b0, 32'h9ABC_DEF0, 1'b1, 14'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 14'd0);
    wait_tx(1'b0);
    check("mr_tx_data", a_tx_data, 8'hAA);
    handshake(1'b0);
    @(negedge CLK);
    check("mr_cpu_rst", a_cpu_rst_n, 1'b1);

    repeat (5) @(negedge CLK);
    check("a_wr_q_empty", a_wr_q.size(), 0);
    check("b_wr_q_empty", b_wr_q.size(), 0);
    check("a_cpu_q_empty", a_cpu_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
